// File: rtl/puc_uart_pkg.sv
// Shared types and helpers for the register UART reporter.
package puc_uart_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_SEND_HEX,
    SEQ_SEND_CR,
    SEQ_SEND_LF
  } seq_state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Map a nibble to its uppercase ASCII hex character.
  function automatic logic [7:0] hexToAscii(input logic [3:0] nibble);
    if (nibble < 4'd10) begin
      return 8'h30 + {4'h0, nibble};
    end else begin
      return 8'h37 + {4'h0, nibble};
    end
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte serializer; ready rises in the last cycle of the stop bit so
// back-to-back bytes leave no idle gap.
module uart_tx_byte
  import puc_uart_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       isReset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ready,
  output logic       txd
);

  localparam int unsigned BAUD_W = $clog2(CLOCKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLOCKS_PER_BIT - 1);

  tx_state_t         state, state_next;
  logic [BAUD_W-1:0] baud_cnt, baud_next;
  logic [2:0]        bit_idx, bit_next;
  logic [7:0]        shift, shift_next;
  logic              txd_next;
  logic              bit_end;

  assign bit_end = (baud_cnt == BAUD_LAST);

  // State register plus baud/bit datapath and registered line output.
  always_ff @(posedge clock) begin
    if (isReset) begin
      state    <= TX_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      txd      <= 1'b1;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_idx  <= bit_next;
      shift    <= shift_next;
      txd      <= txd_next;
    end
  end

  // Next-state: advance one bit every CLOCKS_PER_BIT cycles, load on start && ready.
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_idx;
    shift_next = shift;
    if (state != TX_IDLE) begin
      baud_next = bit_end ? '0 : baud_cnt + BAUD_W'(1);
    end
    unique case (state)
      TX_IDLE: ;
      TX_START: begin
        if (bit_end) begin
          state_next = TX_DATA;
          bit_next   = '0;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            state_next = TX_STOP;
          end else begin
            bit_next   = bit_idx + 3'd1;
            shift_next = {1'b0, shift[7:1]};
          end
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          state_next = TX_IDLE;
        end
      end
      default: state_next = TX_IDLE;
    endcase
    if (start && ready) begin
      state_next = TX_START;
      baud_next  = '0;
      bit_next   = '0;
      shift_next = data;
    end
  end

  // Outputs: handshake ready and the line level for the upcoming cycle.
  always_comb begin
    ready    = (state == TX_IDLE) || ((state == TX_STOP) && bit_end);
    txd_next = 1'b1;
    unique case (state_next)
      TX_START: txd_next = 1'b0;
      TX_DATA:  txd_next = shift_next[0];
      default:  txd_next = 1'b1;
    endcase
  end

endmodule

// File: rtl/register_uart_reporter.sv
// Reports register1Value as uppercase hex + CR LF over UART whenever it
// differs from the last value reported.
module register_uart_reporter
  import puc_uart_pkg::*;
#(
  parameter int unsigned REGISTER_WIDTH = 8,
  parameter int unsigned CLOCKS_PER_BIT = 434
) (
  input  logic                      clock,
  input  logic                      isReset,
  input  logic                      enable,
  input  logic [REGISTER_WIDTH-1:0] register1Value,
  output logic                      txd,
  output logic                      busy,
  output logic [7:0]                sentCount
);

  localparam int unsigned NIBBLES = (REGISTER_WIDTH + 3) / 4;
  localparam int unsigned PAD_W   = NIBBLES * 4;
  localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  seq_state_t                seq_state, seq_next;
  logic [IDX_W-1:0]          char_idx, idx_next;
  logic [REGISTER_WIDTH-1:0] snapshot, last_sent;
  logic                      sent_valid;
  logic                      trigger;
  logic                      tx_start, tx_ready;
  logic [7:0]                tx_data;
  logic [REGISTER_WIDTH-1:0] nib_src;
  logic [IDX_W-1:0]          nib_idx, nib_rev;
  logic [PAD_W-1:0]          shifted;
  logic                      send_cr, send_lf;

  assign trigger = (seq_state == SEQ_IDLE) && enable &&
                   (!sent_valid || (register1Value != last_sent));

  // Sequencer state register.
  always_ff @(posedge clock) begin
    if (isReset) begin
      seq_state <= SEQ_IDLE;
    end else begin
      seq_state <= seq_next;
    end
  end

  // Sequencer next state: each character finishing (tx_ready) advances the report.
  always_comb begin
    seq_next = seq_state;
    idx_next = char_idx;
    unique case (seq_state)
      SEQ_IDLE: begin
        if (trigger) begin
          seq_next = SEQ_SEND_HEX;
          idx_next = '0;
        end
      end
      SEQ_SEND_HEX: begin
        if (tx_ready) begin
          if (char_idx == IDX_LAST) begin
            seq_next = SEQ_SEND_CR;
          end else begin
            idx_next = char_idx + IDX_W'(1);
          end
        end
      end
      SEQ_SEND_CR: if (tx_ready) seq_next = SEQ_SEND_LF;
      SEQ_SEND_LF: if (tx_ready) seq_next = SEQ_IDLE;
      default:     seq_next = SEQ_IDLE;
    endcase
  end

  // Sequencer outputs: the next byte to hand the serializer (first char comes straight from the input).
  always_comb begin
    tx_start = 1'b0;
    nib_src  = snapshot;
    nib_idx  = char_idx + IDX_W'(1);
    send_cr  = 1'b0;
    send_lf  = 1'b0;
    unique case (seq_state)
      SEQ_IDLE: begin
        tx_start = trigger;
        nib_src  = register1Value;
        nib_idx  = '0;
      end
      SEQ_SEND_HEX: begin
        tx_start = tx_ready;
        send_cr  = (char_idx == IDX_LAST);
      end
      SEQ_SEND_CR: begin
        tx_start = tx_ready;
        send_lf  = 1'b1;
      end
      default: ;
    endcase
    nib_rev = IDX_LAST - nib_idx;
    shifted = PAD_W'(nib_src) >> {nib_rev, 2'b00};
    if (send_cr) begin
      tx_data = ASCII_CR;
    end else if (send_lf) begin
      tx_data = ASCII_LF;
    end else begin
      tx_data = hexToAscii(shifted[3:0]);
    end
  end

  // Change detect, snapshot, busy flag and completed-report counter.
  always_ff @(posedge clock) begin
    if (isReset) begin
      char_idx   <= '0;
      snapshot   <= '0;
      last_sent  <= '0;
      sent_valid <= 1'b0;
      busy       <= 1'b0;
      sentCount  <= '0;
    end else begin
      char_idx <= idx_next;
      if (trigger) begin
        snapshot   <= register1Value;
        last_sent  <= register1Value;
        sent_valid <= 1'b1;
        busy       <= 1'b1;
      end
      if ((seq_state == SEQ_SEND_LF) && tx_ready) begin
        busy      <= 1'b0;
        sentCount <= sentCount + 8'd1;
      end
    end
  end

  uart_tx_byte #(
    .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
  ) u_tx (
    .clock  (clock),
    .isReset(isReset),
    .start  (tx_start),
    .data   (tx_data),
    .ready  (tx_ready),
    .txd    (txd)
  );

endmodule

// File: tb/tb_register_uart_reporter.sv
// Bench for register_uart_reporter: 8-bit and 12-bit instances, UART decoders
// feeding a byte scoreboard, plus directed timing checks.
module tb_register_uart_reporter;

  localparam int unsigned CPB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst8, en8, txd8, busy8;
  logic [7:0]  val8, cnt8;
  logic        rst12, en12, txd12, busy12;
  logic [11:0] val12;
  logic [7:0]  cnt12;

  register_uart_reporter #(.REGISTER_WIDTH(8), .CLOCKS_PER_BIT(CPB)) dut8 (
    .clock(clk), .isReset(rst8), .enable(en8), .register1Value(val8),
    .txd(txd8), .busy(busy8), .sentCount(cnt8)
  );

  register_uart_reporter #(.REGISTER_WIDTH(12), .CLOCKS_PER_BIT(CPB)) dut12 (
    .clock(clk), .isReset(rst12), .enable(en12), .register1Value(val12),
    .txd(txd12), .busy(busy12), .sentCount(cnt12)
  );

  int checks   = 0;
  int failures = 0;
  int epoch    = 0;
  logic [7:0] q8[$];
  logic [7:0] q12[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push4(input int which, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d);
    if (which == 0) begin
      q8.push_back(a); q8.push_back(b); q8.push_back(c); q8.push_back(d);
    end else begin
      q12.push_back(a); q12.push_back(b); q12.push_back(c); q12.push_back(d);
    end
  endtask

  // Decode 8N1 frames from one DUT and score them against its queue.
  task automatic uart_mon(input int which);
    logic [7:0] b;
    logic       stop_bit;
    logic [7:0] exp;
    int         ep;
    forever begin
      @(negedge clk);
      if (((which != 0) ? txd12 : txd8) === 1'b0) begin
        ep = epoch;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = (which != 0) ? txd12 : txd8;
        end
        repeat (CPB) @(negedge clk);
        stop_bit = (which != 0) ? txd12 : txd8;
        if (which == 0 && ep != epoch) continue;
        if (((which != 0) ? q12.size() : q8.size()) == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte dut%0d: got %02h expected none", which, b);
        end else begin
          exp = (which != 0) ? q12.pop_front() : q8.pop_front();
          chk($sformatf("byte_dut%0d", which), 32'(b), 32'(exp));
          chk($sformatf("stop_dut%0d", which), 32'(stop_bit), 32'd1);
        end
      end
    end
  endtask

  initial uart_mon(0);
  initial uart_mon(1);

  // Wait until busy has been low for 3 consecutive cycles, bounded.
  task automatic wait_quiet(input int which);
    int low = 0;
    int n   = 0;
    while (low < 3 && n < 2000) begin
      @(negedge clk);
      n++;
      low = (((which != 0) ? busy12 : busy8) === 1'b1) ? 0 : low + 1;
    end
    if (n >= 2000) begin
      checks++;
      failures++;
      $display("FAIL quiet_timeout dut%0d: busy still %0b after %0d cycles", which,
               (which != 0) ? busy12 : busy8, n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n;
    int frame_bits[10];
    logic all_high;
    frame_bits = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 1};

    rst8 = 1'b1; en8 = 1'b0; val8 = 8'h00;
    rst12 = 1'b1; en12 = 1'b0; val12 = 12'h000;

    // Test 1: reset state held for 3 cycles
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_txd", 32'(txd8), 32'd1);
      chk("rst_busy", 32'(busy8), 32'd0);
      chk("rst_count", 32'(cnt8), 32'd0);
    end
    chk("rst_txd12", 32'(txd12), 32'd1);
    chk("rst_count12", 32'(cnt12), 32'd0);

    // Test 2: first report of 0x00, busy exactly 160 cycles
    rst8 = 1'b0; rst12 = 1'b0; en8 = 1'b1;
    push4(0, 8'h30, 8'h30, 8'h0D, 8'h0A);
    n = 0;
    @(negedge clk);
    while (busy8 === 1'b1 && n < 400) begin
      n++;
      @(negedge clk);
    end
    chk("busy_cycles", 32'(n), 32'd160);
    chk("count_after_00", 32'(cnt8), 32'd1);
    wait_quiet(0);

    // Test 3: 0xA5, first frame bit-exact, start bit one cycle after change
    chk("txd_idle_before_A5", 32'(txd8), 32'd1);
    val8 = 8'hA5;
    push4(0, 8'h41, 8'h35, 8'h0D, 8'h0A);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      chk($sformatf("frame41_cyc%0d", k), 32'(txd8), 32'(frame_bits[k / 4]));
    end
    wait_quiet(0);
    chk("count_after_A5", 32'(cnt8), 32'd2);

    // Test 4: intermediate value 0x34 dropped, latest 0x56 sent once
    val8 = 8'h12;
    push4(0, 8'h31, 8'h32, 8'h0D, 8'h0A);
    push4(0, 8'h35, 8'h36, 8'h0D, 8'h0A);
    repeat (20) @(negedge clk);
    chk("busy_during_12", 32'(busy8), 32'd1);
    val8 = 8'h34;
    repeat (50) @(negedge clk);
    val8 = 8'h56;
    wait_quiet(0);
    chk("count_after_56", 32'(cnt8), 32'd4);

    // Test 5: reset during a data bit abandons the frame
    val8 = 8'h5A;
    repeat (10) @(negedge clk);
    chk("busy_before_midreset", 32'(busy8), 32'd1);
    rst8 = 1'b1;
    epoch++;
    @(negedge clk);
    chk("midrst_txd", 32'(txd8), 32'd1);
    chk("midrst_busy", 32'(busy8), 32'd0);
    chk("midrst_count", 32'(cnt8), 32'd0);
    repeat (50) @(negedge clk);
    rst8 = 1'b0;
    push4(0, 8'h35, 8'h41, 8'h0D, 8'h0A);
    wait_quiet(0);
    chk("count_after_5A", 32'(cnt8), 32'd1);

    // Test 6: disabled while toggling, then enable reports 0x02; 12-bit 0xABC
    en8 = 1'b0;
    all_high = 1'b1;
    for (int i = 0; i < 40; i++) begin
      val8 = (i % 10 < 5) ? 8'h01 : 8'h02;
      @(negedge clk);
      if (txd8 !== 1'b1 || busy8 !== 1'b0) all_high = 1'b0;
    end
    chk("idle_while_disabled", 32'(all_high), 32'd1);
    val8 = 8'h02;
    en8 = 1'b1;
    push4(0, 8'h30, 8'h32, 8'h0D, 8'h0A);
    val12 = 12'hABC;
    en12 = 1'b1;
    q12.push_back(8'h41);
    push4(1, 8'h42, 8'h43, 8'h0D, 8'h0A);
    @(negedge clk);
    chk("busy12_started", 32'(busy12), 32'd1);
    wait_quiet(0);
    wait_quiet(1);
    chk("count_after_02", 32'(cnt8), 32'd2);
    chk("count12_after_ABC", 32'(cnt12), 32'd1);

    repeat (10) @(negedge clk);
    chk("q8_drained", 32'(q8.size()), 32'd0);
    chk("q12_drained", 32'(q12.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
